// File: rtl/lfc_bank_mem_arbiter.sv
// Round-robin arbiter that serialises per-bank cache RAM requests onto a single
// req/gnt + rvalid memory port, returning read data and a done pulse per bank.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | scan pending & ~lockout from rr_ptr, latch the winning bank
// REQ     | mem_req asserted with latched we/addr/wdata until mem_gnt
// WAIT_R  | read granted, waiting for mem_rvalid to capture mem_rdata
// DONE    | one-cycle bank_complete pulse, advance rr_ptr, set lockout
module lfc_bank_mem_arbiter #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic [NUM_BANKS-1:0]              bank_REN,
    input  logic [NUM_BANKS-1:0]              bank_WEN,
    input  logic [NUM_BANKS-1:0][ADDR_W-1:0]  bank_addr,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]  bank_store,
    output logic [NUM_BANKS-1:0][DATA_W-1:0]  bank_data,
    output logic [NUM_BANKS-1:0]              bank_complete,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [DATA_W-1:0]                 mem_wdata,
    input  logic                              mem_gnt,
    input  logic                              mem_rvalid,
    input  logic [DATA_W-1:0]                 mem_rdata
);

    localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_R,
        ST_DONE
    } state_t;

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic [IDX_W-1:0]                   r_rr_ptr;
    logic [NUM_BANKS-1:0]               r_lockout;
    logic [IDX_W-1:0]                   r_idx;
    logic                               r_we;
    logic [ADDR_W-1:0]                  r_addr;
    logic [DATA_W-1:0]                  r_wdata;
    logic [NUM_BANKS-1:0][DATA_W-1:0]   r_bank_data;

    logic [NUM_BANKS-1:0]               w_cand;
    logic                               w_found;
    logic [IDX_W-1:0]                   w_sel;
    logic [IDX_W-1:0]                   w_scan;
    logic [NUM_BANKS-1:0]               w_idx_onehot;

    assign w_cand       = (bank_REN | bank_WEN) & ~r_lockout;
    assign w_idx_onehot = {{(NUM_BANKS-1){1'b0}}, 1'b1} << r_idx;

    // First candidate at or after rr_ptr, wrapping at the last bank.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_scan  = r_rr_ptr;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (!w_found && w_cand[w_scan]) begin
                w_found = 1'b1;
                w_sel   = w_scan;
            end
            w_scan = (w_scan == LAST_IDX) ? '0 : w_scan + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_found)    w_state_nxt = ST_REQ;
            ST_REQ:    if (mem_gnt)    w_state_nxt = r_we ? ST_DONE : ST_WAIT_R;
            ST_WAIT_R: if (mem_rvalid) w_state_nxt = ST_DONE;
            ST_DONE:                   w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rr_ptr    <= '0;
            r_lockout   <= '0;
            r_idx       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_bank_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_lockout <= '0;
                    if (w_found) begin
                        r_idx   <= w_sel;
                        r_we    <= bank_WEN[w_sel];
                        r_addr  <= bank_addr[w_sel];
                        r_wdata <= bank_store[w_sel];
                    end
                end
                ST_WAIT_R: begin
                    if (mem_rvalid) r_bank_data[r_idx] <= mem_rdata;
                end
                ST_DONE: begin
                    r_rr_ptr  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                    // Served bank sits out one IDLE scan so a held request is not replayed.
                    r_lockout <= w_idx_onehot;
                end
                default: ;
            endcase
        end
    end

    assign mem_req       = (r_state == ST_REQ);
    assign mem_we        = r_we;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign bank_data     = r_bank_data;
    assign bank_complete = (r_state == ST_DONE) ? w_idx_onehot : '0;

endmodule

// File: tb/tb_lfc_bank_mem_arbiter.sv
// Directed bench for lfc_bank_mem_arbiter: single read/write, stalled grant,
// round-robin with lockout, combined REN/WEN, spurious rvalid, reset mid-read.
module tb_lfc_bank_mem_arbiter;

    logic                  clk;
    logic                  n_rst;
    logic [3:0]            bank_REN;
    logic [3:0]            bank_WEN;
    logic [3:0][31:0]      bank_addr;
    logic [3:0][31:0]      bank_store;
    logic [3:0][31:0]      bank_data;
    logic [3:0]            bank_complete;
    logic                  mem_req;
    logic                  mem_we;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    int                    n_cmp;
    int                    n_err;
    logic [31:0]           exp_data [4];
    int                    exp_order [5];
    logic [31:0]           rd_val;

    lfc_bank_mem_arbiter #(.NUM_BANKS(4), .ADDR_W(32), .DATA_W(32)) u_dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .bank_REN      (bank_REN),
        .bank_WEN      (bank_WEN),
        .bank_addr     (bank_addr),
        .bank_store    (bank_store),
        .bank_data     (bank_data),
        .bank_complete (bank_complete),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] exp_bank_data();
        return {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < 4; i++) exp_data[i] = 32'h0;
    endtask

    task automatic apply_reset();
        n_rst      = 1'b0;
        bank_REN   = '0;
        bank_WEN   = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        clear_exp();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        bank_addr  = '0;
        bank_store = '0;
        exp_order  = '{0, 1, 2, 3, 0};

        // Reset values, observed while reset is held.
        n_rst      = 1'b0;
        bank_REN   = '0;
        bank_WEN   = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        clear_exp();
        #3;
        check_eq("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
        check_eq("rst_complete", bank_complete, 4'b0000);
        check_eq("rst_data", bank_data, 128'h0);
        step();
        #1 n_rst = 1'b1;
        step();

        // Single read on bank 2.
        bank_REN     = 4'b0100;
        bank_addr[2] = 32'h0000_1000;
        mem_gnt      = 1'b1;
        step();
        check_eq("rd_req", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h0000_1000});
        step();
        check_eq("rd_wait_noreq", {mem_req, bank_complete}, 5'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        exp_data[2] = 32'hDEAD_BEEF;
        check_eq("rd_complete", bank_complete, 4'b0100);
        check_eq("rd_data", bank_data, exp_bank_data());
        mem_rvalid = 1'b0;
        bank_REN   = '0;
        step();
        check_eq("rd_complete_once", bank_complete, 4'b0000);

        // Write on bank 1 with grant stalled three cycles.
        mem_gnt       = 1'b0;
        bank_WEN      = 4'b0010;
        bank_addr[1]  = 32'h0000_0020;
        bank_store[1] = 32'hA5A5_0001;
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq("wr_stall_hold", {mem_req, mem_we, mem_addr, mem_wdata},
                     {1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_0001});
            step();
        end
        mem_gnt = 1'b1;
        check_eq("wr_grant_hold", {mem_req, mem_we, mem_addr, mem_wdata},
                 {1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_0001});
        step();
        check_eq("wr_complete", bank_complete, 4'b0010);
        check_eq("wr_data_untouched", bank_data, exp_bank_data());
        bank_WEN = '0;
        step();
        check_eq("wr_idle", {mem_req, bank_complete}, 5'b0);

        // Round-robin with every bank holding a read from reset.
        apply_reset();
        for (int i = 0; i < 4; i++) bank_addr[i] = 32'h100 * (i + 1);
        bank_REN = 4'b1111;
        mem_gnt  = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            check_eq($sformatf("rr_addr_%0d", n), {mem_req, mem_addr},
                     {1'b1, 32'h100 * (exp_order[n] + 1)});
            rd_val     = 32'hC0DE_0000 + n;
            mem_rvalid = 1'b1;
            mem_rdata  = rd_val;
            step();
            step();
            mem_rvalid = 1'b0;
            exp_data[exp_order[n]] = rd_val;
            check_eq($sformatf("rr_complete_%0d", n), bank_complete, 4'b0001 << exp_order[n]);
            check_eq($sformatf("rr_data_%0d", n), bank_data, exp_bank_data());
            if (n == 4) bank_REN = 4'b0001;
            step();
        end
        // Bank 0 alone and locked out: one idle scan with no request.
        step();
        check_eq("lockout_idle", mem_req, 1'b0);
        step();
        check_eq("lockout_reissue", {mem_req, mem_addr}, {1'b1, 32'h0000_0100});
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hC0DE_0005;
        step();
        step();
        mem_rvalid  = 1'b0;
        exp_data[0] = 32'hC0DE_0005;
        check_eq("lockout_complete", bank_complete, 4'b0001);
        bank_REN = '0;
        step();

        // REN and WEN together on bank 3 go out as a write.
        bank_REN      = 4'b1000;
        bank_WEN      = 4'b1000;
        bank_store[3] = 32'h3333_3333;
        step();
        check_eq("rw_issue", {mem_req, mem_we, mem_addr, mem_wdata},
                 {1'b1, 1'b1, 32'h0000_0400, 32'h3333_3333});
        step();
        check_eq("rw_complete", bank_complete, 4'b1000);
        check_eq("rw_data_untouched", bank_data, exp_bank_data());
        bank_REN = '0;
        bank_WEN = '0;
        step();

        // Spurious rvalid in IDLE and in REQ.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        step();
        check_eq("spur_idle", {bank_complete, bank_data}, {4'b0000, exp_bank_data()});
        mem_rvalid    = 1'b0;
        mem_gnt       = 1'b0;
        bank_WEN      = 4'b0001;
        bank_store[0] = 32'h0000_1234;
        step();
        mem_rvalid = 1'b1;
        step();
        check_eq("spur_req", {mem_req, bank_complete, bank_data}, {1'b1, 4'b0000, exp_bank_data()});
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b1;
        step();
        check_eq("spur_wr_complete", {bank_complete, bank_data}, {4'b0001, exp_bank_data()});
        bank_WEN = '0;
        step();

        // Reset asserted while waiting for read data on bank 2.
        bank_REN = 4'b0100;
        step();
        step();
        check_eq("mid_wait_state", {mem_req, mem_addr}, {1'b0, 32'h0000_0300});
        #2 n_rst = 1'b0;
        #1;
        clear_exp();
        check_eq("async_rst_out", {mem_req, mem_we, bank_complete}, 6'b0);
        check_eq("async_rst_data", bank_data, 128'h0);
        @(posedge clk);
        #1;
        bank_REN   = 4'b0101;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        n_rst      = 1'b1;
        step();
        check_eq("post_rst_bank0", {mem_req, mem_addr, bank_complete}, {1'b1, 32'h0000_0100, 4'b0000});
        check_eq("post_rst_late_rvalid", bank_data, 128'h0);
        mem_rvalid = 1'b0;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        step();
        exp_data[0] = 32'h5555_AAAA;
        check_eq("post_rst_complete", {bank_complete, bank_data}, {4'b0001, exp_bank_data()});
        mem_rvalid = 1'b0;
        bank_REN   = '0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
